// File: rtl/control_mc_if.sv
// ---------------------------------------------------------------------------
// control_mc_if
//
// Purpose:
//   Bundles the signals exchanged between the multi-cycle control unit and
//   the rest of the machine: the IR opcode field, the ACC zero flag, the
//   memory-ready handshake and all datapath control strobes.
//
// Modports:
//   master - the control unit (samples Opcode/Zflag/Mem_Ready, drives strobes)
//   slave  - datapath/memory side (drives Opcode/Zflag/Mem_Ready, samples strobes)
//
// Signals:
//   Opcode      IR opcode field (OPW bits)
//   Zflag       accumulator zero flag
//   Mem_Ready   memory completes the current access this cycle
//   Function    ALU function select (FNW bits)
//   SelInc      PC mux: 1 = PC+1, 0 = operand
//   LoadPC      PC load enable
//   LoadIR      IR load enable
//   TrisOperand drive IR operand onto address bus
//   TrisPC      drive PC onto address bus
//   TrisAcc     drive ACC onto data bus
//   Mem_Read    memory read request
//   Mem_Write   memory write request
//   Halted      control unit is in HALTED
//   Fault       control unit is in FAULT
//
// Optional macro CONTROL_MC_INTERRUPT_EN adds IRQ (to the unit) and
// IrqAck, SelVec, LoadEPC (from the unit).
// ---------------------------------------------------------------------------
interface control_mc_if #(
  parameter int OPW = 4,
  parameter int FNW = 4
);

  logic [OPW-1:0] Opcode;
  logic           Zflag;
  logic           Mem_Ready;
  logic [FNW-1:0] Function;
  logic           SelInc;
  logic           LoadPC;
  logic           LoadIR;
  logic           TrisOperand;
  logic           TrisPC;
  logic           TrisAcc;
  logic           Mem_Read;
  logic           Mem_Write;
  logic           Halted;
  logic           Fault;

`ifdef CONTROL_MC_INTERRUPT_EN
  logic           IRQ;
  logic           IrqAck;
  logic           SelVec;
  logic           LoadEPC;

  modport master (
    input  Opcode, Zflag, Mem_Ready, IRQ,
    output Function, SelInc, LoadPC, LoadIR, TrisOperand, TrisPC, TrisAcc,
           Mem_Read, Mem_Write, Halted, Fault, IrqAck, SelVec, LoadEPC
  );

  modport slave (
    output Opcode, Zflag, Mem_Ready, IRQ,
    input  Function, SelInc, LoadPC, LoadIR, TrisOperand, TrisPC, TrisAcc,
           Mem_Read, Mem_Write, Halted, Fault, IrqAck, SelVec, LoadEPC
  );
`else
  modport master (
    input  Opcode, Zflag, Mem_Ready,
    output Function, SelInc, LoadPC, LoadIR, TrisOperand, TrisPC, TrisAcc,
           Mem_Read, Mem_Write, Halted, Fault
  );

  modport slave (
    output Opcode, Zflag, Mem_Ready,
    input  Function, SelInc, LoadPC, LoadIR, TrisOperand, TrisPC, TrisAcc,
           Mem_Read, Mem_Write, Halted, Fault
  );
`endif

endinterface

// File: rtl/control_mc.sv
// ---------------------------------------------------------------------------
// control_mc
//
// Purpose:
//   Multi-cycle control unit for the SimpleRISC datapath. Each instruction is
//   a FETCH followed by an EXECUTE; memory accesses may be stretched by the
//   Mem_Ready handshake, a watchdog forces FAULT if memory stalls too long,
//   and the HALT opcode parks the unit in HALTED. With Mem_Ready tied high
//   the cycle behaviour matches the original two-state unit.
//
// Parameters:
//   OPW      opcode width (opcode constants are zero-extended to it)
//   FNW      ALU function code width
//   MAX_WAIT not-ready cycles tolerated per access (0 disables the watchdog)
//   HALT_OP  opcode decoded as HALT
//
// Ports:
//   Clock  system clock, rising edge
//   Reset  synchronous, active-high reset
//   bus    control_mc_if.master: Opcode, Zflag, Mem_Ready in; Function,
//          SelInc, LoadPC, LoadIR, TrisOperand, TrisPC, TrisAcc, Mem_Read,
//          Mem_Write, Halted, Fault out
//
// Optional feature:
//   Define CONTROL_MC_INTERRUPT_EN to add the IRQ state and the IRQ/IrqAck/
//   SelVec/LoadEPC signals on the interface.
// ---------------------------------------------------------------------------
module control_mc #(
  parameter int             OPW      = 4,
  parameter int             FNW      = 4,
  parameter int             MAX_WAIT = 15,
  parameter logic [OPW-1:0] HALT_OP  = OPW'(4'hF)
) (
  input logic          Clock,
  input logic          Reset,
  control_mc_if.master bus
);

  // Opcode map of the SimpleRISC opcodes package, zero-extended to OPW.
  localparam logic [OPW-1:0] OP_LDA   = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_STA   = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_AND   = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_OR    = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_NOT   = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_LSL   = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_LSR   = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_JMPZ  = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_JMPNZ = OPW'(4'hB);

  // ALU function codes; FN_ACC makes the ALU pass ACC through unchanged.
  localparam logic [FNW-1:0] FN_ACC = FNW'(4'h0);
  localparam logic [FNW-1:0] FN_MEM = FNW'(4'h1);
  localparam logic [FNW-1:0] FN_ADD = FNW'(4'h2);
  localparam logic [FNW-1:0] FN_SUB = FNW'(4'h3);
  localparam logic [FNW-1:0] FN_AND = FNW'(4'h4);
  localparam logic [FNW-1:0] FN_OR  = FNW'(4'h5);
  localparam logic [FNW-1:0] FN_NOT = FNW'(4'h6);
  localparam logic [FNW-1:0] FN_LSL = FNW'(4'h7);
  localparam logic [FNW-1:0] FN_LSR = FNW'(4'h8);

  // A zero MAX_WAIT still needs a one-bit counter so the declarations stay legal.
  localparam int             WCW        = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXECUTE,
    S_HALTED,
    S_FAULT
`ifdef CONTROL_MC_INTERRUPT_EN
    ,
    S_IRQ
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] waitCnt_q, waitCnt_d;

  logic           isHalt;
  logic           isMemRead;
  logic           isMemWrite;
  logic           branchTaken;
  logic [FNW-1:0] decFunc;
  logic           inAccess;
  logic           memWait;
  logic           timeout;
  logic           exDone;

  logic [FNW-1:0] fnSel;
  logic           selInc, loadPC, loadIR;
  logic           trisOperand, trisPC, trisAcc;
  logic           memRead, memWrite;
  logic           halted, fault;
`ifdef CONTROL_MC_INTERRUPT_EN
  logic           irqAck, selVec, loadEPC;
`endif

  // Opcode decode. HALT is checked first so a HALT_OP that overlaps a
  // regular opcode value still behaves as HALT and never touches memory.
  always_comb begin
    isHalt      = (bus.Opcode == HALT_OP);
    isMemRead   = 1'b0;
    isMemWrite  = 1'b0;
    branchTaken = 1'b0;
    decFunc     = FN_ACC;
    if (!isHalt) begin
      case (bus.Opcode)
        OP_LDA:   begin isMemRead = 1'b1; decFunc = FN_MEM; end
        OP_ADD:   begin isMemRead = 1'b1; decFunc = FN_ADD; end
        OP_SUB:   begin isMemRead = 1'b1; decFunc = FN_SUB; end
        OP_AND:   begin isMemRead = 1'b1; decFunc = FN_AND; end
        OP_OR:    begin isMemRead = 1'b1; decFunc = FN_OR;  end
        OP_STA:   isMemWrite  = 1'b1;
        OP_NOT:   decFunc     = FN_NOT;
        OP_LSL:   decFunc     = FN_LSL;
        OP_LSR:   decFunc     = FN_LSR;
        OP_JMP:   branchTaken = 1'b1;
        OP_JMPZ:  branchTaken = bus.Zflag;
        OP_JMPNZ: branchTaken = !bus.Zflag;
        default:  decFunc     = FN_ACC;
      endcase
    end
  end

  // An access is in flight during every FETCH and during EXECUTE of a
  // memory-operand opcode; Mem_Ready is meaningless anywhere else. The
  // watchdog trips when the counter already sits at the limit and memory
  // is still not ready, so exactly MAX_WAIT stalls are tolerated.
  always_comb begin
    inAccess = (state_q == S_FETCH) ||
               ((state_q == S_EXECUTE) && (isMemRead || isMemWrite));
    memWait  = inAccess && !bus.Mem_Ready;
    timeout  = memWait && (MAX_WAIT != 0) && (waitCnt_q == WAIT_LIMIT);
  end

  // Next-state and output decode. Reset overrides everything at the end so
  // the datapath sees idle strobes while Reset is held, whatever state_q is.
  always_comb begin
    state_d     = state_q;
    exDone      = 1'b0;
    fnSel       = FN_ACC;
    selInc      = 1'b0;
    loadPC      = 1'b0;
    loadIR      = 1'b0;
    trisOperand = 1'b0;
    trisPC      = 1'b0;
    trisAcc     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
`ifdef CONTROL_MC_INTERRUPT_EN
    irqAck      = 1'b0;
    selVec      = 1'b0;
    loadEPC     = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        trisPC  = 1'b1;
        memRead = 1'b1;
        if (bus.Mem_Ready) begin
          loadIR  = 1'b1;
          loadPC  = 1'b1;
          selInc  = 1'b1;
          state_d = S_EXECUTE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end

      S_EXECUTE: begin
        trisOperand = 1'b1;
        if (isHalt) begin
          exDone = 1'b1;
        end else if (isMemRead) begin
          // ALU stays on FN_ACC while waiting so ACC is not clobbered by
          // whatever is floating on the data bus.
          memRead = 1'b1;
          if (bus.Mem_Ready) begin
            fnSel  = decFunc;
            exDone = 1'b1;
          end
        end else if (isMemWrite) begin
          memWrite = 1'b1;
          trisAcc  = 1'b1;
          exDone   = bus.Mem_Ready;
        end else if (branchTaken) begin
          loadPC = 1'b1;
          selInc = 1'b0;
          exDone = 1'b1;
        end else begin
          // Register ops, untaken branches and unknown opcodes (FN_ACC = NOP).
          fnSel  = decFunc;
          exDone = 1'b1;
        end

        if (exDone) begin
          state_d = isHalt ? S_HALTED : S_FETCH;
`ifdef CONTROL_MC_INTERRUPT_EN
          if (bus.IRQ) begin
            state_d = S_IRQ;
          end
`endif
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end

      S_HALTED: begin
        halted = 1'b1;
`ifdef CONTROL_MC_INTERRUPT_EN
        if (bus.IRQ) begin
          state_d = S_IRQ;
        end
`endif
      end

      S_FAULT: begin
        fault = 1'b1;
      end

`ifdef CONTROL_MC_INTERRUPT_EN
      S_IRQ: begin
        // One-cycle vector entry: EPC captures the current PC while the PC
        // is loaded with the vector address.
        irqAck  = 1'b1;
        loadEPC = 1'b1;
        loadPC  = 1'b1;
        selVec  = 1'b1;
        selInc  = 1'b0;
        state_d = S_FETCH;
      end
`endif

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (Reset) begin
      state_d     = S_FETCH;
      fnSel       = FN_ACC;
      selInc      = 1'b0;
      loadPC      = 1'b0;
      loadIR      = 1'b0;
      trisOperand = 1'b0;
      trisPC      = 1'b0;
      trisAcc     = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      halted      = 1'b0;
      fault       = 1'b0;
`ifdef CONTROL_MC_INTERRUPT_EN
      irqAck      = 1'b0;
      selVec      = 1'b0;
      loadEPC     = 1'b0;
`endif
    end
  end

  // Wait counter: counts consecutive stalls of the current access and
  // restarts on completion or whenever the state changes. It saturates at
  // the limit; reaching the limit while stalled moves to FAULT anyway.
  always_comb begin
    waitCnt_d = '0;
    if (!Reset && (state_d == state_q) && memWait && (waitCnt_q < WAIT_LIMIT)) begin
      waitCnt_d = waitCnt_q + WCW'(1);
    end
  end

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign bus.Function    = fnSel;
  assign bus.SelInc      = selInc;
  assign bus.LoadPC      = loadPC;
  assign bus.LoadIR      = loadIR;
  assign bus.TrisOperand = trisOperand;
  assign bus.TrisPC      = trisPC;
  assign bus.TrisAcc     = trisAcc;
  assign bus.Mem_Read    = memRead;
  assign bus.Mem_Write   = memWrite;
  assign bus.Halted      = halted;
  assign bus.Fault       = fault;
`ifdef CONTROL_MC_INTERRUPT_EN
  assign bus.IrqAck      = irqAck;
  assign bus.SelVec      = selVec;
  assign bus.LoadEPC     = loadEPC;
`endif

endmodule

// File: tb/tb_control_mc.sv
// ---------------------------------------------------------------------------
// tb_control_mc
//
// Purpose:
//   Self-checking bench for control_mc with default parameters. A table of
//   per-cycle vectors walks a short program and the handshake corners; the
//   watchdog and interrupt scenarios are written out as short sequences.
//   Control strobes are compared as one 10-bit word:
//   {SelInc, LoadPC, LoadIR, TrisOperand, TrisPC, TrisAcc,
//    Mem_Read, Mem_Write, Halted, Fault}
// ---------------------------------------------------------------------------
module tb_control_mc;

  localparam logic [3:0] OP_LDA   = 4'h0;
  localparam logic [3:0] OP_STA   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JMPZ  = 4'hA;
  localparam logic [3:0] OP_JMPNZ = 4'hB;
  localparam logic [3:0] OP_UNK   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] FN_ACC = 4'h0;
  localparam logic [3:0] FN_MEM = 4'h1;
  localparam logic [3:0] FN_ADD = 4'h2;
  localparam logic [3:0] FN_SUB = 4'h3;
  localparam logic [3:0] FN_NOT = 4'h6;

  // Expected strobe words.
  localparam logic [9:0] C_IDLE  = 10'b00000_00000;
  localparam logic [9:0] C_FRDY  = 10'b11101_01000;
  localparam logic [9:0] C_FWAIT = 10'b00001_01000;
  localparam logic [9:0] C_EXRD  = 10'b00010_01000;
  localparam logic [9:0] C_EXST  = 10'b00010_10100;
  localparam logic [9:0] C_EXREG = 10'b00010_00000;
  localparam logic [9:0] C_EXJT  = 10'b01010_00000;
  localparam logic [9:0] C_HALT  = 10'b00000_00010;
  localparam logic [9:0] C_FAULT = 10'b00000_00001;
  localparam logic [9:0] C_IRQ   = 10'b01000_00000;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] expFn;
    logic [9:0] expCtrl;
  } vec_t;

  logic clk;
  logic rst;
  logic irqDrive;
  int   checks;
  int   errors;
  vec_t vecs[$];

  control_mc_if #(.OPW(4), .FNW(4)) bus ();

  control_mc #(
    .OPW      (4),
    .FNW      (4),
    .MAX_WAIT (15),
    .HALT_OP  (4'hF)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle worth of inputs.
  task automatic applyStimulus(input logic r, input logic [3:0] op,
                               input logic z, input logic rdy);
    rst           = r;
    bus.Opcode    = op;
    bus.Zflag     = z;
    bus.Mem_Ready = rdy;
`ifdef CONTROL_MC_INTERRUPT_EN
    bus.IRQ       = irqDrive;
`endif
  endtask

  // Compares Function and the strobe word against expectations.
  task automatic checkOutput(input string name, input logic [3:0] expFn,
                             input logic [9:0] expCtrl);
    logic [9:0] got;
    got = {bus.SelInc, bus.LoadPC, bus.LoadIR, bus.TrisOperand, bus.TrisPC,
           bus.TrisAcc, bus.Mem_Read, bus.Mem_Write, bus.Halted, bus.Fault};
    checks++;
    if (bus.Function !== expFn) begin
      errors++;
      $display("[TB] FAIL %s.fn got %h want %h", name, bus.Function, expFn);
    end
    checks++;
    if (got !== expCtrl) begin
      errors++;
      $display("[TB] FAIL %s.ctrl got %b want %b", name, got, expCtrl);
    end
  endtask

`ifdef CONTROL_MC_INTERRUPT_EN
  // Compares {IrqAck, SelVec, LoadEPC}.
  task automatic checkIrq(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {bus.IrqAck, bus.SelVec, bus.LoadEPC};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s.irq got %b want %b", name, got, exp);
    end
  endtask
`endif

  // One cycle: inputs change on the falling edge, outputs sampled 1 later.
  task automatic step(input string name, input logic r, input logic [3:0] op,
                      input logic z, input logic rdy, input logic [3:0] expFn,
                      input logic [9:0] expCtrl);
    @(negedge clk);
    applyStimulus(r, op, z, rdy);
    #1;
    checkOutput(name, expFn, expCtrl);
  endtask

  task automatic addVec(input string name, input logic r, input logic [3:0] op,
                        input logic z, input logic rdy, input logic [3:0] expFn,
                        input logic [9:0] expCtrl);
    vec_t v;
    v.name = name; v.rst = r; v.op = op; v.z = z; v.rdy = rdy;
    v.expFn = expFn; v.expCtrl = expCtrl;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    irqDrive = 1'b0;
    applyStimulus(1'b1, OP_LDA, 1'b0, 1'b1);

    // Program with ready tied high, then stalls, branches and corners.
    addVec("reset",        1, OP_LDA,   0, 1, FN_ACC, C_IDLE);
    addVec("f_lda",        0, OP_LDA,   0, 1, FN_ACC, C_FRDY);
    addVec("ex_lda",       0, OP_LDA,   0, 1, FN_MEM, C_EXRD);
    addVec("f_add",        0, OP_ADD,   0, 1, FN_ACC, C_FRDY);
    addVec("ex_add",       0, OP_ADD,   0, 1, FN_ADD, C_EXRD);
    addVec("f_sta",        0, OP_STA,   0, 1, FN_ACC, C_FRDY);
    addVec("ex_sta",       0, OP_STA,   0, 1, FN_ACC, C_EXST);
    addVec("f_jmp",        0, OP_JMP,   0, 1, FN_ACC, C_FRDY);
    addVec("ex_jmp",       0, OP_JMP,   0, 1, FN_ACC, C_EXJT);
    addVec("f_wait1",      0, OP_LDA,   0, 0, FN_ACC, C_FWAIT);
    addVec("f_wait2",      0, OP_LDA,   0, 0, FN_ACC, C_FWAIT);
    addVec("f_wait3",      0, OP_LDA,   0, 0, FN_ACC, C_FWAIT);
    addVec("f_ready",      0, OP_LDA,   0, 1, FN_ACC, C_FRDY);
    addVec("lda_wait1",    0, OP_LDA,   0, 0, FN_ACC, C_EXRD);
    addVec("lda_wait2",    0, OP_LDA,   0, 0, FN_ACC, C_EXRD);
    addVec("lda_ready",    0, OP_LDA,   0, 1, FN_MEM, C_EXRD);
    addVec("f_jmpz1",      0, OP_JMPZ,  1, 1, FN_ACC, C_FRDY);
    addVec("jmpz_taken",   0, OP_JMPZ,  1, 1, FN_ACC, C_EXJT);
    addVec("f_jmpz0",      0, OP_JMPZ,  0, 1, FN_ACC, C_FRDY);
    addVec("jmpz_not",     0, OP_JMPZ,  0, 1, FN_ACC, C_EXREG);
    addVec("f_jmpnz0",     0, OP_JMPNZ, 0, 1, FN_ACC, C_FRDY);
    addVec("jmpnz_taken",  0, OP_JMPNZ, 0, 1, FN_ACC, C_EXJT);
    addVec("f_jmpnz1",     0, OP_JMPNZ, 1, 1, FN_ACC, C_FRDY);
    addVec("jmpnz_not",    0, OP_JMPNZ, 1, 1, FN_ACC, C_EXREG);
    addVec("f_not",        0, OP_NOT,   0, 1, FN_ACC, C_FRDY);
    addVec("ex_not",       0, OP_NOT,   0, 0, FN_NOT, C_EXREG);
    addVec("f_sub",        0, OP_SUB,   0, 1, FN_ACC, C_FRDY);
    addVec("ex_sub",       0, OP_SUB,   0, 1, FN_SUB, C_EXRD);
    addVec("f_unk",        0, OP_UNK,   0, 1, FN_ACC, C_FRDY);
    addVec("ex_unk",       0, OP_UNK,   0, 1, FN_ACC, C_EXREG);
    addVec("f_sta2",       0, OP_STA,   0, 1, FN_ACC, C_FRDY);
    addVec("sta_wait1",    0, OP_STA,   0, 0, FN_ACC, C_EXST);
    addVec("sta_wait2",    0, OP_STA,   0, 0, FN_ACC, C_EXST);
    addVec("sta_reset",    1, OP_STA,   0, 0, FN_ACC, C_IDLE);
    addVec("post_rst",     0, OP_STA,   0, 0, FN_ACC, C_FWAIT);
    addVec("f_halt",       0, OP_HALT,  0, 1, FN_ACC, C_FRDY);
    addVec("ex_halt",      0, OP_HALT,  0, 1, FN_ACC, C_EXREG);
    addVec("halted1",      0, OP_LDA,   0, 1, FN_ACC, C_HALT);
    addVec("halted2",      0, OP_LDA,   0, 1, FN_ACC, C_HALT);
    addVec("halt_reset",   1, OP_LDA,   0, 1, FN_ACC, C_IDLE);
    addVec("halt_refetch", 0, OP_LDA,   0, 1, FN_ACC, C_FRDY);

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].rdy,
           vecs[i].expFn, vecs[i].expCtrl);
    end

    // Watchdog: 16 stalled fetch cycles tolerated-then-tripped, FAULT next.
    step("wd_reset", 1'b1, OP_LDA, 1'b0, 1'b0, FN_ACC, C_IDLE);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("wd_wait%0d", i + 1), 1'b0, OP_LDA, 1'b0, 1'b0, FN_ACC, C_FWAIT);
    end
    step("wd_fault",  1'b0, OP_LDA, 1'b0, 1'b0, FN_ACC, C_FAULT);
    step("wd_absorb", 1'b0, OP_LDA, 1'b0, 1'b1, FN_ACC, C_FAULT);
    step("wd_clear",  1'b1, OP_LDA, 1'b0, 1'b1, FN_ACC, C_IDLE);
    step("wd_after",  1'b0, OP_LDA, 1'b0, 1'b1, FN_ACC, C_FRDY);

    // Watchdog near miss: ready arrives on the 16th cycle, no fault.
    step("nm_reset", 1'b1, OP_NOT, 1'b0, 1'b0, FN_ACC, C_IDLE);
    for (int i = 0; i < 15; i++) begin
      step($sformatf("nm_wait%0d", i + 1), 1'b0, OP_NOT, 1'b0, 1'b0, FN_ACC, C_FWAIT);
    end
    step("nm_ready", 1'b0, OP_NOT, 1'b0, 1'b1, FN_ACC, C_FRDY);
    step("nm_exec",  1'b0, OP_NOT, 1'b0, 1'b0, FN_NOT, C_EXREG);

    // Watchdog during a read EXECUTE.
    step("wdx_fetch", 1'b0, OP_ADD, 1'b0, 1'b1, FN_ACC, C_FRDY);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("wdx_wait%0d", i + 1), 1'b0, OP_ADD, 1'b0, 1'b0, FN_ACC, C_EXRD);
    end
    step("wdx_fault", 1'b0, OP_ADD, 1'b0, 1'b0, FN_ACC, C_FAULT);

`ifdef CONTROL_MC_INTERRUPT_EN
    // IRQ at ADD completion, then IRQ while HALTED.
    step("irq_reset", 1'b1, OP_ADD, 1'b0, 1'b1, FN_ACC, C_IDLE);
    step("irq_f_add", 1'b0, OP_ADD, 1'b0, 1'b1, FN_ACC, C_FRDY);
    irqDrive = 1'b1;
    step("irq_ex_add", 1'b0, OP_ADD, 1'b0, 1'b1, FN_ADD, C_EXRD);
    checkIrq("irq_ex_add", 3'b000);
    step("irq_state", 1'b0, OP_ADD, 1'b0, 1'b1, FN_ACC, C_IRQ);
    checkIrq("irq_state", 3'b111);
    irqDrive = 1'b0;
    step("irq_fetch", 1'b0, OP_HALT, 1'b0, 1'b1, FN_ACC, C_FRDY);
    checkIrq("irq_fetch", 3'b000);
    step("irq_ex_halt", 1'b0, OP_HALT, 1'b0, 1'b1, FN_ACC, C_EXREG);
    step("irq_halted", 1'b0, OP_HALT, 1'b0, 1'b1, FN_ACC, C_HALT);
    irqDrive = 1'b1;
    step("irq_halt_req", 1'b0, OP_HALT, 1'b0, 1'b1, FN_ACC, C_HALT);
    step("irq_from_halt", 1'b0, OP_HALT, 1'b0, 1'b1, FN_ACC, C_IRQ);
    checkIrq("irq_from_halt", 3'b111);
    irqDrive = 1'b0;
    step("irq_back", 1'b0, OP_LDA, 1'b0, 1'b1, FN_ACC, C_FRDY);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
